cpu_datapath: RTL

Register-transfer datapath driven by `cpu_fsm`: it owns the shared bus multiplexer, R1, R2, Rout, the four-function ALU and the status flags. It takes `bus_selector`, `alu_control` and the three load enables from the control FSM, plus the board switches. It produces the register contents for LEDs and display and for the FSM's observation. All storage updates on a single clock edge; the bus and ALU are combinational from current register values.

---
 rtl/cpu_datapath_if.sv | 30 +++
 rtl/cpu_datapath.sv | 114 +++++++++++
 2 files changed

// File: rtl/cpu_datapath_if.sv
// Control/observation bundle between cpu_fsm (master) and cpu_datapath (slave).
// Carries switch data, transfer controls and all register/flag observations.
interface cpu_datapath_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] switch_in;
  logic [2:0]       bus_selector;
  logic [1:0]       alu_control;
  logic             r1_enable;
  logic             r2_enable;
  logic             rout_enable;
  logic [WIDTH-1:0] r1_out;
  logic [WIDTH-1:0] r2_out;
  logic [WIDTH-1:0] rout_out;
  logic [WIDTH-1:0] bus_out;
  logic             carry_flag;
  logic             zero_flag;
  logic             result_valid;
  logic [7:0]       op_count;

  modport master (
    output switch_in, bus_selector, alu_control, r1_enable, r2_enable, rout_enable,
    input  r1_out, r2_out, rout_out, bus_out, carry_flag, zero_flag, result_valid, op_count
  );

  modport slave (
    input  switch_in, bus_selector, alu_control, r1_enable, r2_enable, rout_enable,
    output r1_out, r2_out, rout_out, bus_out, carry_flag, zero_flag, result_valid, op_count
  );
endinterface

// File: rtl/cpu_datapath.sv
// Register-transfer datapath: switch synchronizer, shared bus mux, R1/R2/Rout,
// four-function ALU on R1/R2 and registered status flags.
module cpu_datapath #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned IMM_VALUE   = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           reset_n,
  cpu_datapath_if.slave dp_io
);

  localparam logic [WIDTH-1:0] ImmVal = WIDTH'(IMM_VALUE);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] r1_q, r1_d, r2_q, r2_d, rout_q, rout_d;
  logic             carry_q, carry_d, zero_q, zero_d, valid_q, valid_d;
  logic [7:0]       op_count_q, op_count_d;

  logic [WIDTH-1:0] sw_sync;
  logic [WIDTH-1:0] bus;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  assign sw_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = dp_io.switch_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    bus = '0;
    case (dp_io.bus_selector)
      3'b000:  bus = sw_sync;
      3'b001:  bus = r1_q;
      3'b010:  bus = r2_q;
      3'b011:  bus = rout_q;
      3'b101:  bus = ImmVal;
      default: bus = '0;
    endcase
  end

  // Operands are always the registered R1/R2, so a same-edge R1/R2 load cannot leak in.
  assign add_sum = {1'b0, r1_q} + {1'b0, r2_q};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (dp_io.alu_control)
      2'b00: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
      end
      2'b01:   alu_res = r1_q | r2_q;
      2'b10:   alu_res = r1_q ^ r2_q;
      2'b11:   alu_res = ~r1_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    r1_d       = dp_io.r1_enable ? bus : r1_q;
    r2_d       = dp_io.r2_enable ? bus : r2_q;
    rout_d     = rout_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    op_count_d = op_count_q;
    valid_d    = dp_io.rout_enable;
    if (dp_io.rout_enable) begin
      rout_d  = alu_res;
      carry_d = alu_carry;
      zero_d  = (alu_res == '0);
      if (op_count_q != 8'hFF) begin
        op_count_d = op_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      rout_q     <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      valid_q    <= 1'b0;
      op_count_q <= 8'd0;
    end else begin
      sync_q     <= sync_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      rout_q     <= rout_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      valid_q    <= valid_d;
      op_count_q <= op_count_d;
    end
  end

  assign dp_io.r1_out       = r1_q;
  assign dp_io.r2_out       = r2_q;
  assign dp_io.rout_out     = rout_q;
  assign dp_io.bus_out      = bus;
  assign dp_io.carry_flag   = carry_q;
  assign dp_io.zero_flag    = zero_q;
  assign dp_io.result_valid = valid_q;
  assign dp_io.op_count     = op_count_q;

endmodule
